seg_display_scanner: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode 7-segment display. Holds a
//  hex value and scans one digit per refresh slot. Each slot selects the digit's

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_display_scanner_decode.sv | 33 +++
 rtl/seg_display_scanner.sv | 113 +++++++++++
 tb/tb_seg_display_scanner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display scanner.
// All display pins are active-low: a driven 0 lights the segment or digit.
package seg_pkg;

    localparam logic       SEG_ON_LVL    = 1'b0;
    localparam logic       SEG_OFF_LVL   = 1'b1;
    localparam logic       ANODE_OFF_LVL = 1'b1;
    localparam logic       DP_OFF        = 1'b1;
    localparam logic [6:0] SEG_BLANK     = {7{SEG_OFF_LVL}};

    // Segment bundle {a,b,c,d,e,f,g} plus decimal point, as driven on the pins.
    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
    } seg_word_t;

    localparam seg_word_t SEG_WORD_OFF = '{seg: SEG_BLANK, dp: DP_OFF};

endpackage

// File: rtl/seg_display_scanner_decode.sv
// Hex nibble to active-low 7-segment pattern, bit order {a,b,c,d,e,f,g}.
// Purely combinational; the scanner registers its output.
module binaryToSegment
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with a double-buffered
// value, anti-ghost blanking at the start of every slot and leading-zero blanking.
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_en,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   anode_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_OFF_LVL}};
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0]      BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [VAL_W-1:0]      disp_val;
    logic [VAL_W-1:0]      pend_val;
    logic                  pending;

    logic                  slot_end;
    logic                  frame_end;
    logic [3:0]            nibble;
    logic [6:0]            dec_seg;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  lz_blank;
    logic                  lit;
    seg_word_t             word_nxt;
    logic [NUM_DIGITS-1:0] anode_nxt;

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (digit_idx == IDX_LAST);
    assign nibble    = disp_val[4*digit_idx +: 4];

    // upper_zero[i]: every nibble from digit i up to the most significant is zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc           = acc && (disp_val[4*i +: 4] == 4'h0);
            upper_zero[i] = acc;
        end
    end

    assign lz_blank = lz_en && (digit_idx != '0) && upper_zero[digit_idx];
    assign lit      = enable && (div_cnt >= BLANK_END) && !lz_blank;

    binaryToSegment u_dec (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        word_nxt  = SEG_WORD_OFF;
        anode_nxt = ANODE_OFF;
        if (lit) begin
            word_nxt.seg = dec_seg;
            word_nxt.dp  = ~dp_in[digit_idx];
            anode_nxt    = ~(NUM_DIGITS'(1) << digit_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            digit_idx <= '0;
            disp_val  <= '0;
            pend_val  <= '0;
            pending   <= 1'b0;
            anode_out <= ANODE_OFF;
            seg_out   <= SEG_BLANK;
            dp_out    <= DP_OFF;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + DIV_W'(1);
            if (slot_end)
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);

            // Display value only changes between frames so a frame never tears.
            if (frame_end) begin
                if (load)
                    disp_val <= value_in;
                else if (pending)
                    disp_val <= pend_val;
                pending <= 1'b0;
            end else if (load) begin
                pend_val <= value_in;
                pending  <= 1'b1;
            end

            anode_out <= anode_nxt;
            seg_out   <= word_nxt.seg;
            dp_out    <= word_nxt.dp;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with an 8-cycle slot and 2-cycle blank.
// After edge n following reset release, outputs reflect slot state m=n-1.
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value_in = '0;
    logic          load = 1'b0;
    logic [ND-1:0] dp_in = '0;
    logic          lz_en = 1'b0;
    logic          enable = 1'b0;
    logic [ND-1:0] anode_out;
    logic [6:0]    seg_out;
    logic          dp_out;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         e;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } vec_t;

    vec_t tbl [11];

    seg_display_scanner #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .value_in  (value_in),
        .load      (load),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .enable    (enable),
        .anode_out (anode_out),
        .seg_out   (seg_out),
        .dp_out    (dp_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int e);
        while (cyc < e) tick();
    endtask

    task automatic chk(input string nm, input logic [3:0] an, input logic [6:0] sg, input logic dp);
        n_chk++;
        if (anode_out !== an || seg_out !== sg || dp_out !== dp) begin
            n_fail++;
            $display("FAIL %s @%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     nm, cyc, anode_out, seg_out, dp_out, an, sg, dp);
        end
    endtask

    task automatic chk_at(input int e, input string nm, input logic [3:0] an,
                          input logic [6:0] sg, input logic dp);
        run_to(e);
        chk(nm, an, sg, dp);
    endtask

    task automatic load_at(input int e, input logic [15:0] v);
        run_to(e - 1);
        value_in = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{3,  4'b1110, 7'b0000001, 1'b1};
        tbl[1]  = '{11, 4'b1101, 7'b0000001, 1'b0};
        tbl[2]  = '{33, 4'b1111, 7'b1111111, 1'b1};
        tbl[3]  = '{34, 4'b1111, 7'b1111111, 1'b1};
        tbl[4]  = '{35, 4'b1110, 7'b1001100, 1'b1};
        tbl[5]  = '{40, 4'b1110, 7'b1001100, 1'b1};
        tbl[6]  = '{41, 4'b1111, 7'b1111111, 1'b1};
        tbl[7]  = '{43, 4'b1101, 7'b0000110, 1'b0};
        tbl[8]  = '{51, 4'b1011, 7'b0010010, 1'b1};
        tbl[9]  = '{59, 4'b0111, 7'b1001111, 1'b1};
        tbl[10] = '{64, 4'b0111, 7'b1001111, 1'b1};

        // T1: reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_reset", 4'b1111, 7'b1111111, 1'b1);
        end
        rst_n = 1'b1;
        cyc   = 0;

        // T2: load 1234 in frame 0; it appears only from frame 1
        enable   = 1'b1;
        lz_en    = 1'b0;
        dp_in    = 4'b0010;
        value_in = 16'h1234;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        for (int i = 0; i < 11; i++)
            chk_at(tbl[i].e, $sformatf("t2_vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dp);

        // T3: leading-zero blanking, then enable gating
        dp_in = '0;
        lz_en = 1'b1;
        load_at(65, 16'h0005);
        chk_at(99,  "t3_lz5_slot0", 4'b1110, 7'b0100100, 1'b1);
        chk_at(107, "t3_lz5_slot1", 4'b1111, 7'b1111111, 1'b1);
        chk_at(115, "t3_lz5_slot2", 4'b1111, 7'b1111111, 1'b1);
        chk_at(123, "t3_lz5_slot3", 4'b1111, 7'b1111111, 1'b1);
        load_at(129, 16'h0000);
        chk_at(163, "t3_lz0_slot0", 4'b1110, 7'b0000001, 1'b1);
        chk_at(171, "t3_lz0_slot1", 4'b1111, 7'b1111111, 1'b1);
        run_to(194);
        enable = 1'b0;
        chk_at(195, "t3_disabled", 4'b1111, 7'b1111111, 1'b1);
        enable = 1'b1;
        chk_at(196, "t3_reenabled", 4'b1110, 7'b0000001, 1'b1);

        // T4: load mid-frame does not tear the current frame
        lz_en = 1'b0;
        load_at(225, 16'h1234);
        chk_at(259, "t4_old_slot0", 4'b1110, 7'b1001100, 1'b1);
        load_at(266, 16'hABCD);
        chk_at(268, "t4_old_slot1", 4'b1101, 7'b0000110, 1'b1);
        chk_at(275, "t4_old_slot2", 4'b1011, 7'b0010010, 1'b1);
        chk_at(283, "t4_old_slot3", 4'b0111, 7'b1001111, 1'b1);
        chk_at(291, "t4_new_slot0", 4'b1110, 7'b1000010, 1'b1);
        chk_at(299, "t4_new_slot1", 4'b1101, 7'b0110001, 1'b1);

        // T5: load on the frame-boundary cycle goes straight to the display
        load_at(320, 16'hF00F);
        chk_at(323, "t5_slot0", 4'b1110, 7'b0111000, 1'b1);
        chk_at(331, "t5_slot1", 4'b1101, 7'b0000001, 1'b1);
        chk_at(347, "t5_slot3", 4'b0111, 7'b0111000, 1'b1);
        chk_at(355, "t5_no_pending", 4'b1110, 7'b0111000, 1'b1);

        // T6: reset mid-slot2 aborts the frame and clears the value
        dp_in = 4'b0100;
        chk_at(372, "t6_slot2_dp", 4'b1011, 7'b0000001, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("t6_reset", 4'b1111, 7'b1111111, 1'b1);
        rst_n = 1'b1;
        cyc   = 0;
        chk_at(1,  "t6_restart_blank", 4'b1111, 7'b1111111, 1'b1);
        chk_at(3,  "t6_restart_slot0", 4'b1110, 7'b0000001, 1'b1);
        chk_at(11, "t6_restart_slot1", 4'b1101, 7'b0000001, 1'b1);
        chk_at(19, "t6_restart_slot2", 4'b1011, 7'b0000001, 1'b0);
        chk_at(35, "t6_next_frame",    4'b1110, 7'b0000001, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
